// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared MDU definitions: op encodings, occupancy states, default latencies and op-class helpers.
// The MDU datapath imports the same package so both sides agree on encodings.
package mdu_issue_ctrl_pkg;

   typedef enum logic [3:0] {
      MDU_NOP   = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MFHI  = 4'd5,
      MDU_MFLO  = 4'd6,
      MDU_MTHI  = 4'd7,
      MDU_MTLO  = 4'd8
   } mdu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } occ_state_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;
   localparam int CNT_W_DEF       = 5;

   // Ops that launch a multi-cycle MDU computation.
   function automatic logic is_start_op(input mdu_op_e op);
      return (op == MDU_MULT) || (op == MDU_MULTU) ||
             (op == MDU_DIV)  || (op == MDU_DIVU);
   endfunction

   function automatic logic is_div_op(input mdu_op_e op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// D->E MDU issue bundle: D-stage request, E-stage MDU drive, and status back to the pipeline.
interface mdu_issue_ctrl_if;
   import mdu_issue_ctrl_pkg::*;

   // d_valid qualifies the D-stage op; stall_d is the inverse of ready. An op
   // transfers into E only at an edge with d_valid=1, stall_d=0 and e_flush=0.
   logic        d_valid;
   mdu_op_e     d_mdu_op;
   logic [31:0] d_rs;
   logic [31:0] d_rt;
   logic        e_flush;
   logic        mdu_busy;

   logic        mdu_start;
   mdu_op_e     mdu_op;
   logic [31:0] mdu_a;
   logic [31:0] mdu_b;
   logic        stall_d;
   logic        busy_mismatch;
   logic [31:0] stall_cnt;

   modport master (
      output d_valid, d_mdu_op, d_rs, d_rt, e_flush, mdu_busy,
      input  mdu_start, mdu_op, mdu_a, mdu_b, stall_d, busy_mismatch, stall_cnt
   );

   modport slave (
      input  d_valid, d_mdu_op, d_rs, d_rt, e_flush, mdu_busy,
      output mdu_start, mdu_op, mdu_a, mdu_b, stall_d, busy_mismatch, stall_cnt
   );

endinterface

// File: rtl/mdu_issue_ctrl_occ_tracker.sv
// Shadow copy of MDU occupancy: IDLE/BUSY FSM with a down-counter loaded on each start,
// plus a sticky flag raised whenever the shadow disagrees with the real MDU busy.
module mdu_occ_tracker
   import mdu_issue_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  mdu_op_e    i_op,
   input  logic       i_mdu_busy,
   output occ_state_e o_state,
   output logic       o_busy_mismatch
);

   occ_state_e       r_state;
   occ_state_e       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_mismatch;
   logic             w_mismatch_nxt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_mismatch <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_mismatch <= w_mismatch_nxt;
      end
   end

   // The count is loaded with latency-1 so BUSY spans exactly the MDU's busy window.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_mismatch_nxt = r_mismatch | ((r_state == ST_BUSY) != i_mdu_busy);
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_state_nxt = ST_BUSY;
               w_cnt_nxt   = is_div_op(i_op) ? CNT_W'(DIV_CYCLES - 1)
                                             : CNT_W'(MULT_CYCLES - 1);
            end
         end
         ST_BUSY: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign o_state         = r_state;
   assign o_busy_mismatch = r_mismatch;

endmodule

// File: rtl/mdu_issue_ctrl.sv
// D->E issue stage for the MDU: E-stage op/operand register, start pulse, D-stage
// MDU-class stall, and a saturating stall-cycle counter.
module mdu_issue_ctrl
   import mdu_issue_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_reset,
   mdu_issue_ctrl_if.slave  io_mdu,
   output occ_state_e       o_state
);

   logic        r_start;
   mdu_op_e     r_op;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_stall_cnt;
   occ_state_e  w_state;
   logic        w_busy_mismatch;
   logic        w_mdu_class;
   logic        w_stall;

   // A start pending in E also blocks D: the tracker only sees it at the next edge.
   assign w_mdu_class = (io_mdu.d_mdu_op != MDU_NOP);
   assign w_stall     = io_mdu.d_valid & w_mdu_class & ((w_state == ST_BUSY) | r_start);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_start <= 1'b0;
         r_op    <= MDU_NOP;
         r_a     <= '0;
         r_b     <= '0;
      end else if (io_mdu.e_flush) begin
         r_start <= 1'b0;
         r_op    <= MDU_NOP;
      end else if (w_stall || !io_mdu.d_valid) begin
         r_start <= 1'b0;
         r_op    <= MDU_NOP;
      end else begin
         r_start <= is_start_op(io_mdu.d_mdu_op);
         r_op    <= io_mdu.d_mdu_op;
         r_a     <= io_mdu.d_rs;
         r_b     <= io_mdu.d_rt;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   mdu_occ_tracker #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_occ (
      .i_clk           (i_clk),
      .i_rst_n         (i_reset),
      .i_start         (r_start),
      .i_op            (r_op),
      .i_mdu_busy      (io_mdu.mdu_busy),
      .o_state         (w_state),
      .o_busy_mismatch (w_busy_mismatch)
   );

   assign io_mdu.mdu_start     = r_start;
   assign io_mdu.mdu_op        = r_op;
   assign io_mdu.mdu_a         = r_a;
   assign io_mdu.mdu_b         = r_b;
   assign io_mdu.stall_d       = w_stall;
   assign io_mdu.busy_mismatch = w_busy_mismatch;
   assign io_mdu.stall_cnt     = r_stall_cnt;
   assign o_state              = w_state;

endmodule
